// File: rtl/life_row_engine.sv
// ============================================================================
// Module  : life_row_engine
// Purpose : Applies the Game-of-Life rule to the middle row held by the line
//           buffer, LANES pixels per cycle, and writes each next-generation
//           row to the frame memory as one word.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module life_row_engine #(
   parameter int WIDTH  = 1280,
   parameter int HEIGHT = 720,
   parameter int LANES  = 32,
   parameter int SETTLE = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   output logic [9:0]       calc_row_o,
   input  logic [WIDTH-1:0] top_i,
   input  logic [WIDTH-1:0] middle_i,
   input  logic [WIDTH-1:0] bottom_i,
   input  logic             valid_i,
   output logic             wr_en_o,
   output logic [9:0]       wr_addr_o,
   output logic [WIDTH-1:0] wr_data_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int NG = WIDTH / LANES;
   localparam int LW = (NG > 1) ? $clog2(NG) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PW = WIDTH + 2;
   localparam int BW = $clog2(PW);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_CAPTURE = 3'd2,
      S_COMPUTE = 3'd3,
      S_WRITE   = 3'd4,
      S_FINISH  = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [9:0]       calc_row_q, calc_row_d;
   logic             wr_en_q, wr_en_d;
   logic [9:0]       wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0] wr_data_q, wr_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic [WIDTH-1:0] t_q, t_d, m_q, m_d, b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;

   // Snapshot rows padded with a dead column on each side; pixel x sits at x+1.
   logic [PW-1:0]      w_tpad, w_mpad, w_bpad;
   logic [BW-1:0]      w_base;
   logic [LANES+1:0]   w_tw, w_mw, w_bw;
   logic [LANES-1:0]   w_next;
   logic [3:0]         w_n;

   always_comb begin
      w_base = BW'(lane_q) * BW'(LANES);
      w_tpad = {1'b0, t_q, 1'b0};
      w_mpad = {1'b0, m_q, 1'b0};
      w_bpad = {1'b0, b_q, 1'b0};
      w_tw   = w_tpad[w_base +: LANES+2];
      w_mw   = w_mpad[w_base +: LANES+2];
      w_bw   = w_bpad[w_base +: LANES+2];
      w_next = '0;
      w_n    = '0;
      for (int j = 0; j < LANES; j++) begin
         w_n = 4'(w_tw[j]) + 4'(w_tw[j+1]) + 4'(w_tw[j+2])
             + 4'(w_mw[j])                 + 4'(w_mw[j+2])
             + 4'(w_bw[j]) + 4'(w_bw[j+1]) + 4'(w_bw[j+2]);
         w_next[j] = (w_n == 4'd3) | (w_mw[j+1] & (w_n == 4'd2));
      end
   end

   always_comb begin
      state_d    = state_q;
      calc_row_d = calc_row_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      settle_d   = settle_q;
      lane_d     = lane_q;
      t_d        = t_q;
      m_d        = m_q;
      b_d        = b_q;
      result_d   = result_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d    = S_SETTLE;
               calc_row_d = '0;
               busy_d     = 1'b1;
               settle_d   = '0;
            end
         end
         S_SETTLE: begin
            if (settle_q == SW'(SETTLE - 1)) begin
               settle_d = '0;
               state_d  = S_CAPTURE;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         S_CAPTURE: begin
            if (valid_i) begin
               t_d      = top_i;
               m_d      = middle_i;
               b_d      = bottom_i;
               result_d = '0;
               lane_d   = '0;
               state_d  = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            result_d = result_q | (WIDTH'(w_next) << w_base);
            // Register the write one cycle early so wr_en is high exactly in WRITE.
            if (lane_q == LW'(NG - 1)) begin
               state_d   = S_WRITE;
               wr_en_d   = 1'b1;
               wr_addr_d = calc_row_q;
               wr_data_d = result_d;
            end else begin
               lane_d = lane_q + LW'(1);
            end
         end
         S_WRITE: begin
            if (calc_row_q == 10'(HEIGHT - 1)) begin
               state_d    = S_FINISH;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               calc_row_d = '0;
            end else begin
               calc_row_d = calc_row_q + 10'd1;
               state_d    = S_SETTLE;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         calc_row_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         settle_q   <= '0;
         lane_q     <= '0;
         t_q        <= '0;
         m_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         calc_row_q <= calc_row_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         settle_q   <= settle_d;
         lane_q     <= lane_d;
         t_q        <= t_d;
         m_q        <= m_d;
         b_q        <= b_d;
         result_q   <= result_d;
      end
   end

   assign calc_row_o = calc_row_q;
   assign wr_en_o    = wr_en_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

`default_nettype wire
